// File: rtl/ex_dm_stage_buffer.sv
// Elastic EX/DM stage: valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and global enable. Control is masked whenever the stage holds no entry.
module ex_dm_stage_buffer #(
  parameter int                DATA_W     = 32,
  parameter int                CTRL_W     = 16,
  parameter logic [CTRL_W-1:0] CTRL_RESET = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              main_valid, skid_valid, in_fire, out_fire;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // SKID=1 keeps out_ready off the in_ready path; SKID=0 trades that for one entry.
  generate
    if (SKID) begin : g_skid
      assign in_ready = enable & ~skid_valid;
    end else begin : g_noskid
      assign in_ready = enable & (~main_valid | out_ready);
    end
  endgenerate

  assign out_valid = main_valid & enable;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_RESET;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      // Payload registers keep stale contents; the ctrl mask hides them.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = BUSY;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire && SKID) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = BUSY;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_RESET;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_RESET;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule
